// File: rtl/mod12_chk_pkg.sv
// rtl/mod12_chk_pkg.sv - shared types, defaults and prediction helper for mod12_count_checker
//   chk_state_e : TRACK (predicting and comparing) / HALT (frozen after a stop-on-error mismatch)
//   next_t      : predicted next count plus up/down wrap flags
//   next_count  : one step of the counter rule (load priority, then up/down with wrap)
package mod12_chk_pkg;

    localparam int MOD_DEF = 12;
    localparam int W_DEF   = 4;

    typedef enum logic {
        TRACK = 1'b0,
        HALT  = 1'b1
    } chk_state_e;

    typedef struct packed {
        logic [15:0] value;
        logic        wrap_up;
        logic        wrap_dn;
    } next_t;

    // Widths are carried at 16 bits so the helper serves any W/MOD the top is built with.
    // An out-of-range load predicts 0; the real counter's result is don't-care for one cycle.
    function automatic next_t next_count(
        input logic [15:0] cur,
        input logic        load,
        input logic [15:0] din,
        input logic        up_down,
        input logic [15:0] modulus
    );
        next_t r;
        r = '0;
        if (load) begin
            r.value = (din < modulus) ? din : 16'd0;
        end else if (up_down) begin
            if (cur == modulus - 16'd1) begin
                r.value   = 16'd0;
                r.wrap_up = 1'b1;
            end else begin
                r.value = cur + 16'd1;
            end
        end else begin
            if (cur == 16'd0) begin
                r.value   = modulus - 16'd1;
                r.wrap_dn = 1'b1;
            end else begin
                r.value = cur - 16'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mod12_count_checker_sat_counter.sv
// rtl/mod12_count_checker_sat_counter.sv - saturating event counter
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one event this edge
//   freeze   : hold the current value regardless of inc
//   cnt      : current count, sticks at all-ones
module sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             freeze,
    output logic [ERR_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !freeze && (cnt != {ERR_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mod12_count_checker.sv
// rtl/mod12_count_checker.sv - cycle-accurate shadow predictor and checker for the mod-12 up/down counter
//   clk, rst        : shared counter clock, synchronous active-high reset
//   din, load       : tapped counter load value and strobe
//   up_down         : tapped direction, 1 = up
//   count           : observed counter output
//   expected        : prediction for the count sampled at the next edge
//   mismatch        : pulse, observed count differed from prediction
//   illegal_load    : pulse, load with din >= MOD
//   wrap_up/wrap_dn : pulse, predicted wrap MOD-1->0 / 0->MOD-1
//   err_cnt         : saturating mismatch count
//   wrap_cnt        : saturating wrap count, both directions
//   sticky_err      : any mismatch since reset
//   halted          : frozen after a mismatch when STOP_ON_ERR=1
//   cov_hits        : per-value match coverage, only with COUNT_CHK_COVER_EN
//   cov_full        : all values covered, only with COUNT_CHK_COVER_EN
module mod12_count_checker
    import mod12_chk_pkg::*;
#(
    parameter int MOD         = MOD_DEF,
    parameter int W           = W_DEF,
    parameter int ERR_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             load,
    input  logic             up_down,
    input  logic [W-1:0]     count,
    output logic [W-1:0]     expected,
    output logic             mismatch,
    output logic             illegal_load,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] wrap_cnt,
    output logic             sticky_err,
    output logic             halted,
    output logic [MOD-1:0]   cov_hits,
    output logic             cov_full
);

    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    chk_state_e   state_q, state_d;
    logic [W-1:0] exp_q;
    logic         chk_en_q;
    logic         mismatch_q, illegal_q, wrap_up_q, wrap_dn_q, sticky_q;

    logic         tracking;
    logic         miss;
    logic         halt_now;
    logic         advance;
    logic         illegal;
    logic [W-1:0] base;
    next_t        nxt;
    logic         unused_hi;

    assign tracking = (state_q == TRACK);
    assign miss     = tracking && chk_en_q && (count != exp_q);
    assign halt_now = miss && (STOP_ON_ERR != 0);
    assign advance  = tracking && !halt_now;
    assign illegal  = load && (din > MAX_VAL);

    // On a mismatch the prediction restarts from what the counter actually shows,
    // so one glitch costs one mismatch; an out-of-range observation restarts at 0.
    assign base = miss ? ((count > MAX_VAL) ? '0 : count) : exp_q;

    assign nxt       = next_count(16'(base), load, 16'(din), up_down, 16'(MOD));
    assign unused_hi = |nxt.value[15:W];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= TRACK;
        else     state_q <= state_d;
    end

    // next state: HALT is left only through rst
    always_comb begin
        state_d = state_q;
        if (state_q == TRACK && halt_now) state_d = HALT;
    end

    // state-derived outputs
    always_comb begin
        halted = (state_q == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q      <= '0;
            chk_en_q   <= 1'b1;
            mismatch_q <= 1'b0;
            illegal_q  <= 1'b0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            mismatch_q <= miss;
            sticky_q   <= sticky_q | miss;
            illegal_q  <= advance && illegal;
            wrap_up_q  <= advance && nxt.wrap_up;
            wrap_dn_q  <= advance && nxt.wrap_dn;
            if (advance) begin
                exp_q    <= nxt.value[W-1:0];
                // The counter's value after an illegal load is unknown, skip one compare.
                chk_en_q <= !illegal;
            end
        end
    end

    sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (miss),
        .freeze (!tracking),
        .cnt    (err_cnt)
    );

    sat_counter #(.ERR_W(ERR_W)) u_wrap_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (advance && (nxt.wrap_up || nxt.wrap_dn)),
        .freeze (!tracking),
        .cnt    (wrap_cnt)
    );

    assign expected     = exp_q;
    assign mismatch     = mismatch_q;
    assign illegal_load = illegal_q;
    assign wrap_up      = wrap_up_q;
    assign wrap_dn      = wrap_dn_q;
    assign sticky_err   = sticky_q;

`ifdef COUNT_CHK_COVER_EN
    logic [MOD-1:0] cov_q;
    logic           cov_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cov_q      <= '0;
            cov_full_q <= 1'b0;
        end else begin
            cov_full_q <= &cov_q;
            for (int v = 0; v < MOD; v++) begin
                if (tracking && chk_en_q && (count == exp_q) && (exp_q == W'(v))) cov_q[v] <= 1'b1;
            end
        end
    end

    assign cov_hits = cov_q;
    assign cov_full = cov_full_q;
`else
    assign cov_hits = '0;
    assign cov_full = 1'b0;
`endif

endmodule

// File: tb/tb_mod12_count_checker.sv
// tb/tb_mod12_count_checker.sv - randomized self-checking bench for mod12_count_checker
module tb_mod12_count_checker;

    localparam int MOD = 12;
    localparam int W   = 4;
    localparam int EW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b0;
    logic up_down = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] count = '0;

    logic [1:0][W-1:0]   expv;
    logic [1:0]          mm, il, wu, wd, st, hl, cf;
    logic [1:0][EW-1:0]  ec, wc;
    logic [1:0][MOD-1:0] cov;

    always #5 clk = ~clk;

    mod12_count_checker #(.MOD(MOD), .W(W), .ERR_W(EW), .STOP_ON_ERR(0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .load(load), .up_down(up_down), .count(count),
        .expected(expv[0]), .mismatch(mm[0]), .illegal_load(il[0]), .wrap_up(wu[0]),
        .wrap_dn(wd[0]), .err_cnt(ec[0]), .wrap_cnt(wc[0]), .sticky_err(st[0]),
        .halted(hl[0]), .cov_hits(cov[0]), .cov_full(cf[0])
    );

    mod12_count_checker #(.MOD(MOD), .W(W), .ERR_W(EW), .STOP_ON_ERR(1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .load(load), .up_down(up_down), .count(count),
        .expected(expv[1]), .mismatch(mm[1]), .illegal_load(il[1]), .wrap_up(wu[1]),
        .wrap_dn(wd[1]), .err_cnt(ec[1]), .wrap_cnt(wc[1]), .sticky_err(st[1]),
        .halted(hl[1]), .cov_hits(cov[1]), .cov_full(cf[1])
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    endtask

    // Reference model: one entry per instance (index = STOP_ON_ERR value).
    int m_exp[2], m_chk[2], m_halt[2], m_err[2], m_wc[2], m_st[2];
    int m_mm[2], m_il[2], m_wu[2], m_wd[2], m_cf[2];
    logic [MOD-1:0] m_cov[2];

    // Behavioural counter that drives count.
    int ctr = 0;
    int shown = 0;

    task automatic model_edge();
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_exp[s] = 0; m_chk[s] = 1; m_halt[s] = 0; m_err[s] = 0; m_wc[s] = 0;
                m_st[s] = 0; m_mm[s] = 0; m_il[s] = 0; m_wu[s] = 0; m_wd[s] = 0;
                m_cov[s] = '0; m_cf[s] = 0;
            end else begin
                m_cf[s] = &m_cov[s];
                m_mm[s] = 0; m_il[s] = 0; m_wu[s] = 0; m_wd[s] = 0;
                if (!m_halt[s]) begin
                    int miss, cur;
                    miss = (m_chk[s] != 0) && (int'(count) != m_exp[s]);
                    if (m_chk[s] != 0 && !miss) m_cov[s][count] = 1'b1;
                    if (miss) begin
                        m_mm[s] = 1; m_st[s] = 1;
                        if (m_err[s] < 255) m_err[s]++;
                    end
                    if (miss && s == 1) begin
                        m_halt[s] = 1;
                    end else begin
                        cur = miss ? ((int'(count) < MOD) ? int'(count) : 0) : m_exp[s];
                        if (load) begin
                            if (int'(din) < MOD) m_exp[s] = int'(din);
                            else begin m_exp[s] = 0; m_il[s] = 1; end
                        end else if (up_down) begin
                            m_wu[s] = (cur == MOD - 1);
                            m_exp[s] = (cur + 1) % MOD;
                        end else begin
                            m_wd[s] = (cur == 0);
                            m_exp[s] = (cur + MOD - 1) % MOD;
                        end
                        if ((m_wu[s] || m_wd[s]) && m_wc[s] < 255) m_wc[s]++;
                        m_chk[s] = m_il[s] ? 0 : 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("expected[%0d]", s),     32'(expv[s]), 32'(m_exp[s]));
            check($sformatf("mismatch[%0d]", s),     32'(mm[s]),   32'(m_mm[s]));
            check($sformatf("illegal_load[%0d]", s), 32'(il[s]),   32'(m_il[s]));
            check($sformatf("wrap_up[%0d]", s),      32'(wu[s]),   32'(m_wu[s]));
            check($sformatf("wrap_dn[%0d]", s),      32'(wd[s]),   32'(m_wd[s]));
            check($sformatf("err_cnt[%0d]", s),      32'(ec[s]),   32'(m_err[s]));
            check($sformatf("wrap_cnt[%0d]", s),     32'(wc[s]),   32'(m_wc[s]));
            check($sformatf("sticky_err[%0d]", s),   32'(st[s]),   32'(m_st[s]));
            check($sformatf("halted[%0d]", s),       32'(hl[s]),   32'(m_halt[s]));
`ifdef COUNT_CHK_COVER_EN
            check($sformatf("cov_hits[%0d]", s),     32'(cov[s]),  32'(m_cov[s]));
            check($sformatf("cov_full[%0d]", s),     32'(cf[s]),   32'(m_cf[s]));
`else
            check($sformatf("cov_hits_off[%0d]", s), 32'(cov[s]),  32'd0);
            check($sformatf("cov_full_off[%0d]", s), 32'(cf[s]),   32'd0);
`endif
        end
    endtask

    // One clock: apply inputs (optionally glitch the counter), step model, step counter, check.
    task automatic cycle(input logic r, input logic l, input logic [W-1:0] d, input logic ud,
                         input logic f, input logic [W-1:0] fv);
        rst = r; load = l; din = d; up_down = ud;
        if (f) begin
            shown = int'(fv);
            ctr   = (int'(fv) < MOD) ? int'(fv) : 0;
        end
        count = W'(shown);
        model_edge();
        if (r) begin
            ctr = 0; shown = 0;
        end else if (l) begin
            if (int'(d) < MOD) begin ctr = int'(d); shown = ctr; end
            else begin ctr = 0; shown = int'($urandom_range(0, 15)); end
        end else if (ud) begin
            ctr = (ctr + 1) % MOD; shown = ctr;
        end else begin
            ctr = (ctr + MOD - 1) % MOD; shown = ctr;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        @(negedge clk);
        // reset, then a clean up-sweep through the wrap
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        check("reset_expected", 32'(expv[0]), 32'd0);
        check("reset_err_cnt",  32'(ec[0]),   32'd0);
        for (int i = 0; i < 14; i++) cycle(0, 0, 0, 1, 0, 0);
        check("up_wrap_cnt", 32'(wc[0]), 32'd1);
        check("up_no_err",   32'(ec[0]), 32'd0);
`ifdef COUNT_CHK_COVER_EN
        check("sweep_cov_hits", 32'(cov[0]), 32'hFFF);
        check("sweep_cov_full", 32'(cf[0]),  32'd1);
`endif
        // load 5, then count down through the 0 -> 11 wrap
        cycle(0, 1, 5, 0, 0, 0);
        check("load5_expected", 32'(expv[0]), 32'd5);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0, 0);
        check("down_expected", 32'(expv[0]), 32'd10);
        check("down_wrap_cnt", 32'(wc[0]),   32'd2);
        // out-of-range load
        cycle(0, 1, 13, 1, 0, 0);
        check("illegal_pulse", 32'(il[0]), 32'd1);
        cycle(0, 0, 0, 1, 0, 0);
        check("illegal_no_mismatch", 32'(mm[0]),   32'd0);
        check("illegal_resume",      32'(expv[0]), 32'd1);
        // counter glitch to 7 while 3 is predicted
        cycle(0, 1, 3, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 7);
        check("fault_mismatch", 32'(mm[0]),   32'd1);
        check("fault_err_cnt",  32'(ec[0]),   32'd1);
        check("fault_sticky",   32'(st[0]),   32'd1);
        check("fault_resync",   32'(expv[0]), 32'd8);
        check("stop_halted",    32'(hl[1]),   32'd1);
        cycle(0, 0, 0, 1, 0, 0);
        check("fault_single",   32'(mm[0]),   32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 2);
        check("stop_err_frozen", 32'(ec[1]), 32'd1);
        cycle(1, 0, 0, 1, 0, 0);
        check("rst_halted", 32'(hl[1]), 32'd0);
        check("rst_err",    32'(ec[1]), 32'd0);
        check("rst_sticky", 32'(st[1]), 32'd0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r, l, ud, f;
            logic [W-1:0] d, fv;
            r  = ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 7) == 0);
            ud = 1'($urandom_range(0, 1));
            f  = ($urandom_range(0, 24) == 0);
            d  = W'($urandom_range(0, 15));
            fv = W'($urandom_range(0, 15));
            cycle(r, l, d, ud, f, fv);
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mod12_count_checker.md
Name: mod12_count_checker

Overview:
- Downstream consumer of the mod-12 up/down counter. Sits beside the counter on the same clock and taps its control inputs (din, load, up_down) and its count output.
- Maintains a cycle-accurate prediction of the counter, flags mismatches and counts wrap events and errors.
- Synthesizable, so it can serve as an on-chip self-check and as the reference model for the bench.

Parameters:
- MOD, 12, counter modulus; legal count range 0..MOD-1.
- W, 4, count/din width; must satisfy 2**W >= MOD.
- ERR_W, 8, width of the saturating error and wrap counters.
- STOP_ON_ERR, 0, 1 = halt tracking on first mismatch; 0 = resync and continue.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset, shared with the counter.
- din  in  W  counter load value.
- load  in  1  counter load strobe.
- up_down  in  1  1 = count up, 0 = count down.
- count  in  W  observed counter output.
- expected  out  W  predicted count for the current cycle.
- mismatch  out  1  one-cycle pulse: count != expected.
- illegal_load  out  1  one-cycle pulse: load with din >= MOD.
- wrap_up  out  1  pulse: predicted MOD-1 -> 0 via up-count.
- wrap_dn  out  1  pulse: predicted 0 -> MOD-1 via down-count.
- err_cnt  out  ERR_W  saturating mismatch count.
- wrap_cnt  out  ERR_W  saturating count of wrap events, both directions.
- sticky_err  out  1  set on any mismatch, cleared only by rst.
- halted  out  1  high in HALT state.
- cov_hits  out  MOD  value-coverage bitmap (optional feature).
- cov_full  out  1  all values hit (optional feature).

Behaviour:
- Reset: clk and rst only, synchronous active-high. While rst is high:
  - exp_q = 0, state = TRACK, chk_en = 1.
  - All pulses, counters and sticky_err go to 0; halted = 0; cov_hits = 0.
- expected = exp_q, driven combinationally from the register.
- Every edge with rst=0, in TRACK:
  - Compare: if chk_en and count != exp_q, mismatch is registered high for one cycle; err_cnt increments, saturating at all-ones; sticky_err is set.
  - Predict the next value:
    - load=1 and din < MOD: next = din.
    - load=1 and din >= MOD: next = 0, illegal_load pulses, and chk_en = 0 for the next cycle only, because the counter's out-of-range load result is unspecified.
    - load=0, up_down=1: next = (exp_q == MOD-1) ? 0 : exp_q+1. wrap_up pulses on the wrap.
    - load=0, up_down=0: next = (exp_q == 0) ? MOD-1 : exp_q-1. wrap_dn pulses on the wrap.
    - load always has priority over counting.
  - Any wrap increments wrap_cnt, saturating.
  - Zero latency: count sampled at edge k is compared with the prediction made at edge k-1.
- On mismatch:
  - STOP_ON_ERR=0: the next prediction uses the observed count in place of exp_q (resync), so a single fault yields a single mismatch.
  - STOP_ON_ERR=1: state goes to HALT.
- HALT: exp_q, err_cnt and wrap_cnt are frozen; halted=1; all pulses are 0. Exit only via rst.
- Observed count >= MOD is always a mismatch. A resync to an out-of-range value predicts 0.
- rst asserted mid-operation: everything returns to reset values on that edge. The first post-reset compare expects 0.
- Registered pulse outputs align with the cycle after the edge where the event was sampled.

Optional Feature:
- Macro COUNT_CHK_COVER_EN.
- Defined:
  - cov_hits[v] sets when a matching count == v is observed in TRACK.
  - cov_full = &cov_hits, registered.
  - Both are cleared by rst.
- Undefined: cov_hits and cov_full are tied to 0 and no coverage flops are generated. Ports remain present.

Decomposition:
- Package mod12_chk_pkg holds:
  - state enum chk_state_e {TRACK, HALT};
  - localparams MOD_DEF=12, W_DEF=4;
  - function next_count(cur, load, din, up_down) returning the next value plus wrap_up/wrap_dn flags.
- One sub-module, sat_counter (parameter ERR_W; inputs inc, freeze), instantiated twice for err_cnt and wrap_cnt.

Test Plan:
- rst for 2 cycles, then up_down=1 for 14 cycles with a correct counter. Required: no mismatch; wrap_up pulses once, after 11 -> 0; wrap_cnt = 1.
- load=1, din=5, then up_down=0 for 7 cycles. Required: expected runs 5,4,3,2,1,0,11,10; wrap_dn pulses once.
- load=1, din=13. Required: illegal_load pulses; no mismatch on the following cycle; tracking continues from 0.
- STOP_ON_ERR=0, inject count=7 when expected=3. Required: exactly one mismatch; err_cnt = 1; sticky_err = 1; the next prediction is 8.
- STOP_ON_ERR=1, same fault. Required: halted = 1; err_cnt stays 1 despite further faults; rst clears all outputs.
- COUNT_CHK_COVER_EN defined, full up-sweep of 12 values. Required: cov_hits = 12'hFFF; cov_full = 1 on the following cycle.
